mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access stage directly downstream of the execute stage. Takes the executed instruction,
//  its ALU result (load/store address) and store data, and runs a req/ack transaction on the data bus.
//  Returns formatted writeback data to the writeback stage and stalls upstream while busy.
//  Non-memory instructions pass through with a one-cycle register delay.
// PARAMETERS
//  TIMEOUT  8'd255  max cycles spent in BUSY without MemAck before BusErr is raised (range 1..255)
// PORTS
//  CLK       in   1   clock; all state changes on posedge
//  RST       in   1   synchronous, active-high reset
//  InValid   in   1   Ins/Result/Rdata2 valid; sampled only in IDLE
//  Ins       in   32  instruction from execute; Op = Ins[31:26]
//  Result    in   32  execute result: effective address for memory ops, passthrough value otherwise
//  Rdata2    in   32  store data (rt)
//  Stall     out  1   registered; 1 while state==BUSY; upstream holds its inputs while high
//  OutValid  out  1   one-cycle pulse: Wdata/AdrErr/BusErr valid
//  Wdata     out  32  load data or passed-through Result
//  AdrErr    out  1   pulse together with OutValid: misaligned access, no bus cycle issued
//  BusErr    out  1   pulse together with OutValid: MemAck not seen within TIMEOUT cycles
//  MemReq    out  1   bus request, held high until ack or timeout
//  MemWe     out  1   1 = store
//  MemAddr   out  32  word address {addr[31:2],2'b00}
//  MemBe     out  4   byte enables, bit3 = bits[31:24] (big-endian)
//  MemWdata  out  32  store data, lane-replicated
//  MemAck    in   1   bus acknowledge; MemRdata valid in the same cycle
//  MemRdata  in   32  load data
// BEHAVIOUR
//  - Memory ops (Op): LB 20h, LH 21h, LW 23h, LBU 24h, LHU 25h, SB 28h, SH 29h, SW 2Bh. All other Op = non-memory.
//  - Reset: state IDLE; every output 0; timeout counter 0. Reset mid-transaction drops MemReq at that edge and
//    abandons the access: no OutValid, no error pulse.
//  - FSM: IDLE, BUSY.
//  - IDLE, InValid=0: outputs idle (OutValid=0).
//  - IDLE, InValid & non-mem: next edge OutValid=1, Wdata=Result. Stays IDLE (latency 1).
//  - IDLE, InValid & mem, misaligned (halfword addr[0]!=0, word addr[1:0]!=0): next edge OutValid=1,
//    AdrErr=1, Wdata=0. No MemReq. Stays IDLE.
//  - IDLE, InValid & mem, aligned: capture Op/addr[1:0]/Rdata2. Next edge: BUSY, Stall=1, MemReq=1, and
//    MemWe/MemAddr/MemBe/MemWdata driven. These are held stable until MemReq falls.
//  - BUSY: MemAck sampled only while MemReq=1; MemAck in IDLE is ignored.
//    MemAck may arrive in the first BUSY cycle. On MemAck, at the next edge: IDLE, MemReq=0, Stall=0,
//    OutValid=1. Wdata = formatted load data, or 0 for stores.
//  - Timeout: counter clears on entry to BUSY and increments each BUSY cycle without ack. If the counter
//    reaches TIMEOUT-1 with no ack: next edge IDLE, MemReq=0, OutValid=1, BusErr=1, Wdata=0.
//    Ack in the same cycle as the timeout: ack wins.
//  - Inputs are ignored while BUSY; a new instruction is accepted no earlier than the cycle after Stall falls.
//  - Byte lanes (off = addr[1:0]):
//    * Byte access: lane 3-off.
//    * Halfword access: off 0 -> BE 1100, off 2 -> BE 0011.
//    * Word access: BE 1111.
//    * Loads read MemBe as above.
//  - Store data: SB {4{Rdata2[7:0]}}; SH {2{Rdata2[15:0]}}; SW Rdata2.
//  - Load format: selected lane right-justified. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
//  - Latency: accept at T, MemReq from T+1, ack at T+k (k>=1), OutValid at T+k+1.
// TESTING
//  1. RST high 2 cycles mid-BUSY -> all outputs 0 next edge; MemReq low; no OutValid afterwards.
//  2. LW, Result=0x100, ack 3 cycles after MemReq with MemRdata=0xDEADBEEF
//     -> MemAddr=0x100, MemBe=1111, Stall high 3 cycles, then OutValid + Wdata=0xDEADBEEF.
//  3. LB at 0x103, MemRdata=0x123456F0 -> MemBe=0001, Wdata=0xFFFFFFF0; LBU same -> Wdata=0x000000F0.
//  4. SH, Result=0x202, Rdata2=0x0000ABCD -> MemWe=1, MemAddr=0x200, MemBe=0011, MemWdata=0xABCDABCD,
//     Wdata=0 on completion.
//  5. LW at 0x101 -> AdrErr+OutValid next cycle, MemReq never rises.
//     TIMEOUT=4, LW with no ack -> BusErr+OutValid after 4 BUSY cycles.
//  6. ADD with Result=0x5 -> OutValid, Wdata=0x5 one cycle later; back-to-back non-mem ops -> one OutValid per cycle.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage that sits directly after execute.
//
// Non-memory instructions are registered for one cycle and passed on to
// writeback. Misaligned loads/stores are reported straight away with AdrErr,
// and no bus cycle is issued for them. Aligned loads/stores run one req/ack
// transaction on the data bus. Stall is held high for the whole of that
// transaction. If no acknowledge arrives within TIMEOUT busy cycles, the stage
// gives up and reports BusErr.
//
// Handshake: MemReq and the bus fields (MemWe/MemAddr/MemBe/MemWdata) rise
// together and stay constant until the cycle after MemAck, or until timeout.
// MemAck and MemRdata count only while MemReq is high, and at any other time
// they are ignored. While Stall is high, the upstream stage holds its inputs
// and this stage ignores them. OutValid is a one-cycle pulse, and Wdata,
// AdrErr and BusErr are meaningful only during that pulse.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   InValid/Ins/Result/Rdata2   instruction, address-or-value, store data
//   Stall             high while a bus transaction is outstanding
//   OutValid/Wdata/AdrErr/BusErr  writeback result pulse
//   MemReq/MemWe/MemAddr/MemBe/MemWdata  data bus request side
//   MemAck/MemRdata   data bus response side
//   dbg_state         current FSM state (0 = IDLE, 1 = BUSY)
module mem_stage #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        InValid,
    input  logic [31:0] Ins,
    input  logic [31:0] Result,
    input  logic [31:0] Rdata2,
    output logic        Stall,
    output logic        OutValid,
    output logic [31:0] Wdata,
    output logic        AdrErr,
    output logic        BusErr,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [3:0]  MemBe,
    output logic [31:0] MemWdata,
    input  logic        MemAck,
    input  logic [31:0] MemRdata,
    output logic        dbg_state
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    state_t      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        stall_q, stall_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] wdata_q, wdata_d;
    logic        adr_err_q, adr_err_d;
    logic        bus_err_q, bus_err_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    // Decode of the incoming instruction.
    logic [5:0]  in_op;
    logic [1:0]  in_off;
    logic        in_is_mem, in_is_store, in_misaligned;
    logic [3:0]  in_be;
    logic [31:0] in_store_data;

    always_comb begin
        in_op         = Ins[31:26];
        in_off        = Result[1:0];
        in_is_mem     = 1'b0;
        in_misaligned = 1'b0;
        in_be         = 4'b0000;
        in_store_data = 32'h0;
        in_is_store   = (in_op == OP_SB) || (in_op == OP_SH) || (in_op == OP_SW);
        case (in_op)
            OP_LB, OP_LBU, OP_SB: begin
                in_is_mem     = 1'b1;
                // Big-endian: byte offset 0 is the top lane.
                in_be         = 4'b0001 << (2'd3 - in_off);
                in_store_data = {4{Rdata2[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                in_is_mem     = 1'b1;
                in_misaligned = in_off[0];
                in_be         = in_off[1] ? 4'b0011 : 4'b1100;
                in_store_data = {2{Rdata2[15:0]}};
            end
            OP_LW, OP_SW: begin
                in_is_mem     = 1'b1;
                in_misaligned = |in_off;
                in_be         = 4'b1111;
                in_store_data = Rdata2;
            end
            default: ;
        endcase
    end

    // Right-justify the addressed lane of the returned word.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        case (off_q)
            2'd0:    ld_byte = MemRdata[31:24];
            2'd1:    ld_byte = MemRdata[23:16];
            2'd2:    ld_byte = MemRdata[15:8];
            default: ld_byte = MemRdata[7:0];
        endcase
        ld_half = off_q[1] ? MemRdata[15:0] : MemRdata[31:16];
        case (op_q)
            OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_data = {24'h0, ld_byte};
            OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data = {16'h0, ld_half};
            default: ld_data = MemRdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        stall_d     = stall_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        // Result signals are single-cycle pulses by default.
        out_valid_d = 1'b0;
        wdata_d     = 32'h0;
        adr_err_d   = 1'b0;
        bus_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (InValid) begin
                    if (!in_is_mem) begin
                        out_valid_d = 1'b1;
                        wdata_d     = Result;
                    end else if (in_misaligned) begin
                        out_valid_d = 1'b1;
                        adr_err_d   = 1'b1;
                    end else begin
                        state_d     = BUSY;
                        stall_d     = 1'b1;
                        op_d        = in_op;
                        off_d       = in_off;
                        cnt_d       = 8'd0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = in_is_store;
                        mem_addr_d  = {Result[31:2], 2'b00};
                        mem_be_d    = in_be;
                        mem_wdata_d = in_store_data;
                    end
                end
            end
            BUSY: begin
                // An acknowledge in the final timeout cycle still completes the access.
                if ((MemAck && mem_req_q) || (cnt_q == TIMEOUT - 8'd1)) begin
                    state_d     = IDLE;
                    stall_d     = 1'b0;
                    out_valid_d = 1'b1;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 32'h0;
                    mem_be_d    = 4'b0000;
                    mem_wdata_d = 32'h0;
                    if (MemAck && mem_req_q) begin
                        wdata_d = mem_we_q ? 32'h0 : ld_data;
                    end else begin
                        bus_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            op_q        <= 6'h0;
            off_q       <= 2'd0;
            cnt_q       <= 8'd0;
            stall_q     <= 1'b0;
            out_valid_q <= 1'b0;
            wdata_q     <= 32'h0;
            adr_err_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            stall_q     <= stall_d;
            out_valid_q <= out_valid_d;
            wdata_q     <= wdata_d;
            adr_err_q   <= adr_err_d;
            bus_err_q   <= bus_err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign Stall     = stall_q;
    assign OutValid  = out_valid_q;
    assign Wdata     = wdata_q;
    assign AdrErr    = adr_err_q;
    assign BusErr    = bus_err_q;
    assign MemReq    = mem_req_q;
    assign MemWe     = mem_we_q;
    assign MemAddr   = mem_addr_q;
    assign MemBe     = mem_be_q;
    assign MemWdata  = mem_wdata_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage. A transaction-level model predicts every output
// on every cycle. Directed scenarios also pin the model with literal values.
module tb_mem_stage;
    localparam int TMO = 4;

    localparam logic [5:0] LB  = 6'h20;
    localparam logic [5:0] LH  = 6'h21;
    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] LBU = 6'h24;
    localparam logic [5:0] LHU = 6'h25;
    localparam logic [5:0] SB  = 6'h28;
    localparam logic [5:0] SH  = 6'h29;
    localparam logic [5:0] SW  = 6'h2B;
    localparam logic [5:0] ADD = 6'h00;

    logic        CLK, RST, InValid, MemAck;
    logic [31:0] Ins, Result, Rdata2, MemRdata;
    logic        Stall, OutValid, AdrErr, BusErr, MemReq, MemWe, dbg_state;
    logic [31:0] Wdata, MemAddr, MemWdata;
    logic [3:0]  MemBe;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 0;

    mem_stage #(.TIMEOUT(8'(TMO))) dut (
        .CLK(CLK), .RST(RST), .InValid(InValid), .Ins(Ins), .Result(Result),
        .Rdata2(Rdata2), .Stall(Stall), .OutValid(OutValid), .Wdata(Wdata),
        .AdrErr(AdrErr), .BusErr(BusErr), .MemReq(MemReq), .MemWe(MemWe),
        .MemAddr(MemAddr), .MemBe(MemBe), .MemWdata(MemWdata), .MemAck(MemAck),
        .MemRdata(MemRdata), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- model ----------------
    function automatic int acc_size(input logic [5:0] op);
        case (op)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, SW:      return 4;
            default:     return 0;
        endcase
    endfunction

    function automatic bit is_store(input logic [5:0] op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    // Lanes are numbered from the top byte (big-endian), so an access of s bytes at
    // offset off covers enable bits [3-off : 4-s-off].
    function automatic logic [3:0] model_be(input int s, input int off);
        int v;
        v = ((1 << s) - 1) << (4 - s - off);
        return 4'(v);
    endfunction

    function automatic logic [31:0] model_store(input int s, input logic [31:0] d);
        case (s)
            1:       return {4{d[7:0]}};
            2:       return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [5:0] op, input int off,
                                               input logic [31:0] rd);
        int s;
        logic [31:0] mask, v;
        s = acc_size(op);
        mask = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 32'd1);
        v = (rd >> (8 * (4 - s - off))) & mask;
        if (((op == LB) || (op == LH)) && v[8 * s - 1]) v = v | ~mask;
        return v;
    endfunction

    logic        e_stall, e_ov, e_adr, e_bus, e_req, e_we;
    logic [31:0] e_wdata, e_addr, e_mwd;
    logic [3:0]  e_be;
    bit          m_busy;
    int          m_cycles;
    logic [5:0]  m_op;
    logic [31:0] m_addr;

    initial begin
        e_stall = 0; e_ov = 0; e_adr = 0; e_bus = 0; e_req = 0; e_we = 0;
        e_wdata = 0; e_addr = 0; e_mwd = 0; e_be = 0;
        m_busy = 0; m_cycles = 0; m_op = 0; m_addr = 0;
    end

    task automatic model_bus_idle();
        e_req = 0; e_we = 0; e_addr = 0; e_be = 0; e_mwd = 0;
    endtask

    always @(posedge CLK) begin
        e_ov = 0; e_adr = 0; e_bus = 0; e_wdata = 0;
        if (RST) begin
            m_busy = 0;
            model_bus_idle();
        end else if (!m_busy) begin
            if (InValid) begin
                if (acc_size(Ins[31:26]) == 0) begin
                    e_ov = 1; e_wdata = Result;
                end else if ((Result % acc_size(Ins[31:26])) != 0) begin
                    e_ov = 1; e_adr = 1;
                end else begin
                    m_busy = 1; m_cycles = 0; m_op = Ins[31:26]; m_addr = Result;
                    e_req = 1; e_we = is_store(m_op);
                    e_addr = {m_addr[31:2], 2'b00};
                    e_be = model_be(acc_size(m_op), int'(m_addr[1:0]));
                    e_mwd = model_store(acc_size(m_op), Rdata2);
                end
            end
        end else begin
            m_cycles++;
            if (MemAck) begin
                m_busy = 0; model_bus_idle(); e_ov = 1;
                e_wdata = is_store(m_op) ? 32'h0 : model_load(m_op, int'(m_addr[1:0]), MemRdata);
            end else if (m_cycles == TMO) begin
                m_busy = 0; model_bus_idle(); e_ov = 1; e_bus = 1;
            end
        end
        e_stall = m_busy;
    end

    // ---------------- scoreboard ----------------
    logic [105:0] got_vec, exp_vec;
    always @(negedge CLK) begin
        if (chk_en) begin
            got_vec = {Stall, OutValid, Wdata, AdrErr, BusErr, MemReq, MemWe, MemAddr, MemBe, MemWdata};
            exp_vec = {e_stall, e_ov, e_wdata, e_adr, e_bus, e_req, e_we, e_addr, e_be, e_mwd};
            n_total++;
            if (got_vec !== exp_vec)
                $display("FAIL cycle_model t=%0t got=%h exp=%h", $time, got_vec, exp_vec);
            else
                n_pass++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", name, got, exp);
        else n_pass++;
    endtask

    // ---------------- drivers ----------------
    logic        c_req, c_we, o_ov, o_adr, o_bus;
    logic [31:0] c_addr, c_mwd, o_wdata;
    logic [3:0]  c_be;
    int          c_stall;

    // Issue one instruction. ack_cycle is the BUSY cycle (1-based) in which MemAck
    // is raised; 0 means never. noise keeps a non-memory instruction on the inputs
    // while busy, and the stage must ignore it.
    task automatic mem_txn(input logic [5:0] op, input logic [31:0] res, input logic [31:0] rd2,
                           input int ack_cycle, input logic [31:0] rdata, input bit noise);
        InValid = 1; Ins = {op, 26'h0}; Result = res; Rdata2 = rd2;
        @(posedge CLK); #1;
        if (noise) begin
            Ins = {ADD, 26'h21}; Result = 32'hBAD0_BAD0;
        end else begin
            InValid = 0;
        end
        c_req = MemReq; c_we = MemWe; c_addr = MemAddr; c_be = MemBe; c_mwd = MemWdata;
        c_stall = 0;
        for (int n = 1; n <= 300; n++) begin
            if (OutValid || !Stall) break;
            c_stall++;
            if (n == ack_cycle) begin MemAck = 1; MemRdata = rdata; end
            @(posedge CLK); #1;
            MemAck = 0;
        end
        InValid = 0;
        o_ov = OutValid; o_wdata = Wdata; o_adr = AdrErr; o_bus = BusErr;
        @(posedge CLK); #1;
    endtask

    bit saw_ov;

    initial begin
        RST = 1; InValid = 0; Ins = 0; Result = 0; Rdata2 = 0; MemAck = 0; MemRdata = 0;
        @(posedge CLK); #1;
        chk_en = 1;
        check("reset_outvalid", {31'h0, OutValid}, 32'h0);
        check("reset_memreq", {31'h0, MemReq}, 32'h0);
        @(posedge CLK); #1;
        RST = 0;

        // Plain LW, ack in the third BUSY cycle.
        mem_txn(LW, 32'h100, 32'h0, 3, 32'hDEAD_BEEF, 0);
        check("lw_addr", c_addr, 32'h100);
        check("lw_be", {28'h0, c_be}, 32'hF);
        check("lw_req", {31'h0, c_req}, 32'h1);
        check("lw_stall_cycles", c_stall, 3);
        check("lw_outvalid", {31'h0, o_ov}, 32'h1);
        check("lw_wdata", o_wdata, 32'hDEAD_BEEF);

        // LB / LBU at the lowest lane.
        mem_txn(LB, 32'h103, 32'h0, 1, 32'h1234_56F0, 0);
        check("lb_be", {28'h0, c_be}, 32'h1);
        check("lb_wdata", o_wdata, 32'hFFFF_FFF0);
        mem_txn(LBU, 32'h103, 32'h0, 2, 32'h1234_56F0, 0);
        check("lbu_wdata", o_wdata, 32'h0000_00F0);

        // SH to the low halfword; busy-time noise on the inputs must be ignored.
        mem_txn(SH, 32'h202, 32'h0000_ABCD, 2, 32'h0, 1);
        check("sh_we", {31'h0, c_we}, 32'h1);
        check("sh_addr", c_addr, 32'h200);
        check("sh_be", {28'h0, c_be}, 32'h3);
        check("sh_mwdata", c_mwd, 32'hABCD_ABCD);
        check("sh_wdata", o_wdata, 32'h0);

        // Misaligned word load: immediate AdrErr, no bus cycle.
        mem_txn(LW, 32'h101, 32'h0, 0, 32'h0, 0);
        check("adr_err", {31'h0, o_adr}, 32'h1);
        check("adr_outvalid", {31'h0, o_ov}, 32'h1);
        check("adr_no_req", {31'h0, c_req}, 32'h0);
        check("adr_wdata", o_wdata, 32'h0);

        // Timeout without ack.
        mem_txn(LW, 32'h400, 32'h0, 0, 32'h0, 0);
        check("tmo_buserr", {31'h0, o_bus}, 32'h1);
        check("tmo_stall_cycles", c_stall, TMO);
        check("tmo_wdata", o_wdata, 32'h0);

        // Ack in the last allowed BUSY cycle wins over the timeout.
        mem_txn(LH, 32'h402, 32'h0, TMO, 32'h1111_8001, 0);
        check("ackwin_buserr", {31'h0, o_bus}, 32'h0);
        check("ackwin_wdata", o_wdata, 32'hFFFF_8001);

        // Further lane patterns checked by the cycle model.
        mem_txn(LHU, 32'h500, 32'h0, 1, 32'h8001_7FFF, 0);
        check("lhu_wdata", o_wdata, 32'h0000_8001);
        mem_txn(SB, 32'h601, 32'h0000_005A, 1, 32'h0, 0);
        check("sb_be", {28'h0, c_be}, 32'h4);
        check("sb_mwdata", c_mwd, 32'h5A5A_5A5A);
        mem_txn(SW, 32'h700, 32'hCAFE_F00D, 1, 32'h0, 0);
        mem_txn(SH, 32'h701, 32'h0, 0, 32'h0, 0);
        check("sh_misaligned", {31'h0, o_adr}, 32'h1);

        // MemAck while idle is ignored.
        MemAck = 1; MemRdata = 32'h5555_5555;
        @(posedge CLK); #1;
        MemAck = 0;
        check("idle_ack_ignored", {31'h0, OutValid}, 32'h0);

        // Non-memory ops: single ADD, then back to back.
        mem_txn(ADD, 32'h5, 32'h0, 0, 32'h0, 0);
        check("add_outvalid", {31'h0, o_ov}, 32'h1);
        check("add_wdata", o_wdata, 32'h5);
        InValid = 1; Ins = {ADD, 26'h20};
        for (int i = 0; i < 3; i++) begin
            Result = 32'h10 + 32'(i);
            @(posedge CLK); #1;
            check("b2b_outvalid", {31'h0, OutValid}, 32'h1);
            check("b2b_wdata", Wdata, 32'h10 + 32'(i));
        end
        InValid = 0;
        @(posedge CLK); #1;
        check("b2b_end", {31'h0, OutValid}, 32'h0);

        // Reset in the middle of BUSY abandons the access.
        InValid = 1; Ins = {LW, 26'h0}; Result = 32'h300;
        @(posedge CLK); #1;
        InValid = 0;
        check("pre_rst_req", {31'h0, MemReq}, 32'h1);
        @(posedge CLK); #1;
        RST = 1;
        @(posedge CLK); #1;
        check("rst_req", {31'h0, MemReq}, 32'h0);
        check("rst_stall", {31'h0, Stall}, 32'h0);
        check("rst_state", {31'h0, dbg_state}, 32'h0);
        @(posedge CLK); #1;
        RST = 0;
        saw_ov = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK); #1;
            if (OutValid || MemReq) saw_ov = 1;
        end
        check("rst_no_outvalid", {31'h0, saw_ov}, 32'h0);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
